// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the shared RAM arbiter: one instance per port.
// master = requester (CPU or display engine), slave = arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) ();
  logic              req;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one synchronous RAM between CPU (port C) and display engine (port D):
// CPU-first priority, display starvation guard, locked bursts, 2-cycle read return.
module mem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      c_port,
  mem_arbiter_if.slave      d_port,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOCK_C = 2'd1;
  localparam logic [1:0] LOCK_D = 2'd2;

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [1:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              c_gnt;
  logic              d_gnt;
  logic              rd_pend;
  logic              rd_owner;   // 1 = port D issued the pending read
  logic              c_rvalid;
  logic              d_rvalid;
  logic [DATA_W-1:0] c_rdata;
  logic [DATA_W-1:0] d_rdata;

  // Grants are suppressed while reset is held so every output reads 0.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      case (state)
        LOCK_C: c_gnt = c_port.req;
        LOCK_D: d_gnt = d_port.req;
        default: begin
          if (c_port.req && d_port.req) begin
            if (wait_cnt == WAIT_MAX) d_gnt = 1'b1;
            else                      c_gnt = 1'b1;
          end else begin
            c_gnt = c_port.req;
            d_gnt = d_port.req;
          end
        end
      endcase
    end
  end

  always_comb begin
    mem_en    = c_gnt | d_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (c_gnt) begin
      mem_we    = c_port.we;
      mem_addr  = c_port.addr;
      mem_wdata = c_port.wdata;
    end else if (d_gnt) begin
      mem_we    = d_port.we;
      mem_addr  = d_port.addr;
      mem_wdata = d_port.wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      if (c_gnt)      state <= c_port.lock ? LOCK_C : IDLE;
      else if (d_gnt) state <= d_port.lock ? LOCK_D : IDLE;

      // Saturating count keeps D's claim alive through a C lock.
      if (!d_port.req || d_gnt)    wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Read return: RAM data arrives the cycle after the grant and is
  // registered into the issuing port's rdata one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      c_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      rd_pend  <= mem_en && !mem_we;
      rd_owner <= d_gnt;
      c_rvalid <= rd_pend && !rd_owner;
      d_rvalid <= rd_pend && rd_owner;
      if (rd_pend && !rd_owner) c_rdata <= mem_rdata;
      if (rd_pend && rd_owner)  d_rdata <= mem_rdata;
    end
  end

  assign c_port.gnt    = c_gnt;
  assign d_port.gnt    = d_gnt;
  assign c_port.rvalid = c_rvalid;
  assign d_port.rvalid = d_rvalid;
  assign c_port.rdata  = c_rdata;
  assign d_port.rdata  = d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model (grant rules, read-return queue, shadow RAM).
module tb_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) c_bus ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) d_bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk       (clk),
    .rst       (rst),
    .c_port    (c_bus),
    .d_port    (d_bus),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // RAM macro behaviour
  logic [7:0] ram     [4096];
  logic [7:0] ref_mem [4096];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  typedef struct {
    logic        we;
    logic        lock;
    logic [11:0] addr;
    logic [7:0]  wdata;
  } req_t;

  typedef struct {
    int         port;
    logic [7:0] data;
    int         due;
  } rd_t;

  req_t c_q[$];
  req_t d_q[$];
  rd_t  rd_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int m_own = 0;   // 0 none, 1 C holds lock, 2 D holds lock
  int m_wait = 0;
  logic [7:0] e_crd = 8'h00;
  logic [7:0] e_drd = 8'h00;
  bit c_en = 1'b1;
  bit d_en = 1'b1;
  bit g_c, g_d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.we    = ($urandom % 3) == 0;
    r.lock  = ($urandom % 4) == 0;
    r.addr  = 12'($urandom % 64);
    r.wdata = 8'($urandom);
    return r;
  endfunction

  function automatic req_t rd_req(input logic [11:0] a, input logic lk);
    req_t r;
    r.we = 1'b0; r.lock = lk; r.addr = a; r.wdata = 8'h00;
    return r;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic step();
    bit cr, dr, gc, gd, ew, rvc, rvd;
    logic [11:0] ea;
    logic [7:0]  ewd;
    rd_t r;

    cr = (c_q.size() > 0) && c_en;
    dr = (d_q.size() > 0) && d_en;
    c_bus.req = cr;
    if (cr) begin
      c_bus.we = c_q[0].we; c_bus.lock = c_q[0].lock;
      c_bus.addr = c_q[0].addr; c_bus.wdata = c_q[0].wdata;
    end else begin
      c_bus.we = 1'b0; c_bus.lock = 1'b0; c_bus.addr = '0; c_bus.wdata = '0;
    end
    d_bus.req = dr;
    if (dr) begin
      d_bus.we = d_q[0].we; d_bus.lock = d_q[0].lock;
      d_bus.addr = d_q[0].addr; d_bus.wdata = d_q[0].wdata;
    end else begin
      d_bus.we = 1'b0; d_bus.lock = 1'b0; d_bus.addr = '0; d_bus.wdata = '0;
    end
    #1;

    gc = 1'b0; gd = 1'b0;
    if (!rst) begin
      if (m_own == 1)      gc = cr;
      else if (m_own == 2) gd = dr;
      else if (cr && dr) begin
        if (m_wait >= MW) gd = 1'b1;
        else              gc = 1'b1;
      end else begin
        gc = cr; gd = dr;
      end
    end
    ew = 1'b0; ea = '0; ewd = '0;
    if (gc) begin ew = c_bus.we; ea = c_bus.addr; ewd = c_bus.wdata; end
    else if (gd) begin ew = d_bus.we; ea = d_bus.addr; ewd = d_bus.wdata; end

    rvc = 1'b0; rvd = 1'b0;
    if (rst) begin
      rd_q.delete(); e_crd = 8'h00; e_drd = 8'h00;
    end else if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      r = rd_q.pop_front();
      if (r.port == 0) begin rvc = 1'b1; e_crd = r.data; end
      else             begin rvd = 1'b1; e_drd = r.data; end
    end

    check("c_gnt",     32'(c_bus.gnt),    32'(gc));
    check("d_gnt",     32'(d_bus.gnt),    32'(gd));
    check("mem_en",    32'(mem_en),       32'(gc | gd));
    check("mem_we",    32'(mem_we),       32'(ew));
    check("mem_addr",  32'(mem_addr),     32'(ea));
    check("mem_wdata", 32'(mem_wdata),    32'(ewd));
    check("c_rvalid",  32'(c_bus.rvalid), 32'(rvc));
    check("d_rvalid",  32'(d_bus.rvalid), 32'(rvd));
    check("c_rdata",   32'(c_bus.rdata),  32'(e_crd));
    check("d_rdata",   32'(d_bus.rdata),  32'(e_drd));

    if (rst) begin
      m_own = 0; m_wait = 0;
    end else begin
      if (gc || gd) begin
        if (ew) ref_mem[ea] = ewd;
        else    rd_q.push_back('{gd ? 1 : 0, ref_mem[ea], cyc + 2});
      end
      if (gc) m_own = c_bus.lock ? 1 : 0;
      if (gd) m_own = d_bus.lock ? 2 : 0;
      if (dr && !gd) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
      else           m_wait = 0;
    end

    g_c = c_bus.gnt;
    g_d = d_bus.gnt;
    @(negedge clk);
    if (g_c && cr) void'(c_q.pop_front());
    if (g_d && dr) void'(d_q.pop_front());
    cyc++;
  endtask

  task automatic idle(input int n);
    c_q.delete(); d_q.delete();
    repeat (n) step();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[12'h200] = 8'hA2; ref_mem[12'h200] = 8'hA2;
    mem_rdata = 8'h00;
    c_bus.req = 1'b0; c_bus.we = 1'b0; c_bus.lock = 1'b0; c_bus.addr = '0; c_bus.wdata = '0;
    d_bus.req = 1'b0; d_bus.we = 1'b0; d_bus.lock = 1'b0; d_bus.addr = '0; d_bus.wdata = '0;
    rst = 1'b1;
    @(negedge clk);
    repeat (2) step();
    rst = 1'b0;

    // Single CPU read of a known byte
    c_q.push_back(rd_req(12'h200, 1'b0));
    repeat (3) step();
    check("a2_rdata", 32'(c_bus.rdata), 32'h0000_00A2);
    idle(1);

    // Both ports request every cycle: D wins every fifth cycle
    for (int i = 0; i < 30; i++) begin
      c_q.push_back(rd_req(12'(i), 1'b0));
      d_q.push_back(rd_req(12'(12'h400 + i), 1'b0));
    end
    for (int i = 0; i < 20; i++) begin
      step();
      check("starve_d_gnt", 32'(g_d), 32'((i % 5) == 4));
    end
    idle(3);

    // Locked display burst while the CPU requests constantly
    for (int i = 0; i < 5; i++) d_q.push_back(rd_req(12'(12'h050 + i), i < 4));
    for (int i = 0; i < 6; i++) begin
      if (i == 1) for (int k = 0; k < 8; k++) c_q.push_back(rd_req(12'(12'h600 + k), 1'b0));
      step();
      check("burst_c_gnt", 32'(g_c), 32'(i == 5));
      check("burst_d_gnt", 32'(g_d), 32'(i < 5));
    end
    idle(3);

    // Write then read-back of the same address
    c_q.push_back('{1'b1, 1'b0, 12'h300, 8'h33});
    c_q.push_back(rd_req(12'h300, 1'b0));
    repeat (4) step();
    check("wr_rd_data", 32'(c_bus.rdata), 32'h0000_0033);
    idle(1);

    // Reset lands on the cycle after a display read grant
    d_q.push_back(rd_req(12'h123, 1'b0));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(3);

    // Ports take turns, one read each per cycle
    for (int i = 0; i < 10; i++) begin
      c_q.push_back(rd_req(12'(12'h700 + i), 1'b0));
      d_q.push_back(rd_req(12'(12'h800 + i), 1'b0));
    end
    for (int i = 0; i < 20; i++) begin
      c_en = (i % 2) == 0;
      d_en = (i % 2) == 1;
      step();
      check("alt_c_gnt", 32'(g_c), 32'((i % 2) == 0));
    end
    c_en = 1'b1; d_en = 1'b1;
    idle(3);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if (c_q.size() == 0 && ($urandom % 4) != 0) c_q.push_back(rand_req());
      if (d_q.size() == 0 && ($urandom % 4) != 0) d_q.push_back(rand_req());
      rst = ($urandom % 500) == 0;
      step();
    end
    rst = 1'b0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single CHIP-8 4 KiB synchronous RAM between the CPU (port C) and the display/sprite engine (port D). It sits between `cpu`, the display engine and the RAM macro. It grants at most one access per cycle using CPU-first priority with a starvation guard for the display. It supports locked bursts, so a requester can perform multi-byte sequences such as sprite rows or BCD stores without interleaving from the other port.

## Interface
- `ADDR_W`, 12, address width (4096 bytes)
- `DATA_W`, 8, data width
- `MAX_WAIT`, 4, consecutive denied cycles after which port D wins arbitration (≥1)

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `c_req`, `d_req`  in  1  access request; hold until granted
- `c_we`, `d_we`  in  1  1 = write, 0 = read
- `c_lock`, `d_lock`  in  1  keep ownership after this access
- `c_addr`, `d_addr`  in  ADDR_W  byte address
- `c_wdata`, `d_wdata`  in  DATA_W  write data
- `c_gnt`, `d_gnt`  out  1  access accepted this cycle (combinational)
- `c_rvalid`, `d_rvalid`  out  1  read data valid (registered)
- `c_rdata`, `d_rdata`  out  DATA_W  read data (registered)
- `mem_en`, `mem_we`  out  1  RAM enable / write enable (combinational)
- `mem_addr`  out  ADDR_W  RAM address
- `mem_wdata`  out  DATA_W  RAM write data
- `mem_rdata`  in  DATA_W  RAM read data, valid one cycle after `mem_en` with `mem_we`=0

## Operation
- Request rule: a requester holds `req`/`we`/`addr`/`wdata`/`lock` stable until it sees `gnt`=1. A single-cycle grant consumes one access. The requester may present a new request in the next cycle.
- Ownership FSM states:
  - IDLE: normal arbitration.
  - LOCK_C: only port C may be granted.
  - LOCK_D: only port D may be granted.
- IDLE arbitration:
  - Only one `req` is high: that port is granted.
  - Both are high and `wait_cnt` < `MAX_WAIT`: C is granted.
  - Both are high and `wait_cnt` = `MAX_WAIT`: D is granted.
- Lock transitions:
  - A grant with `lock`=1 moves the FSM to that port's LOCK state.
  - A granted access with `lock`=0 by the owner returns the FSM to IDLE.
  - In a LOCK state the other port is never granted, whatever `wait_cnt` is.
- `wait_cnt`:
  - Increments, saturating at `MAX_WAIT`, each cycle `d_req`=1 and `d_gnt`=0.
  - Clears on `d_gnt` or when `d_req`=0.
- RAM drive: in the grant cycle, `mem_en`=1 and `mem_we`/`mem_addr`/`mem_wdata` are taken from the granted port. With no grant, `mem_en`=0, `mem_we`=0, and addr/wdata are 0.
- Reads:
  - A registered `rd_pend` and `owner` are set in the grant cycle.
  - On the next edge after `mem_rdata` is valid, `mem_rdata` is captured into the owner's `rdata` and that port's `rvalid` pulses for 1 cycle.
  - The non-owner's `rdata` holds its previous value.
- Writes: complete in the grant cycle; no `rvalid`.

## Timing
- Reset values:
  - `c_gnt`=`d_gnt`=0 (no requests asserted).
  - `c_rvalid`=`d_rvalid`=0, `c_rdata`=`d_rdata`=0.
  - `mem_en`=`mem_we`=0, `mem_addr`=`mem_wdata`=0.
  - FSM=IDLE, `wait_cnt`=0, `rd_pend`=0.
- Read latency: grant in cycle N → RAM samples at the edge ending N → `mem_rdata` valid in N+1 → `rvalid`/`rdata` high in N+2.
- Throughput: one grant per cycle. Back-to-back reads from either or both ports pipeline, with each `rvalid` returned to the port granted two cycles earlier, in grant order.
- Simultaneous events:
  - Owner's unlock access and the other port's request in the same cycle: only the owner is granted; the other port is eligible from the next cycle.
  - `wait_cnt` saturation while the FSM is LOCK_C: D waits and the count stays at `MAX_WAIT`. D wins the first IDLE arbitration.
- Locked owner with `req`=0: the FSM stays in its LOCK state and nobody is granted (no timeout).
- `rst` mid-operation:
  - Asynchronously clears all state.
  - A read granted before reset returns no `rvalid`.
  - A write whose grant cycle is cut short by reset is undefined in RAM.

## Test plan
- Reset, then C reads addr 0x200 (RAM holds 0xA2): `c_gnt` in cycle 1, `c_rvalid`=1 with `c_rdata`=0xA2 in cycle 3. The D outputs stay 0 throughout.
- C and D request continuously, MAX_WAIT=4: C granted 4 cycles, D granted in the 5th, then the pattern repeats. `wait_cnt` reads 0 after each D grant.
- D reads 0x050–0x054 with `lock`=1 on the first four accesses and 0 on the last, while C requests constantly: C is not granted until the cycle after D's 5th grant. Five consecutive `d_rvalid` pulses return the RAM bytes in order.
- C writes 0x33 to 0x300 then reads 0x300 in the next cycle: `mem_we`=1 in the first grant cycle, `c_rdata`=0x33 two cycles after the read grant.
- D read granted at cycle N, `rst` asserted for one cycle at N+1: no `d_rvalid` at N+2, and all outputs are 0 during reset.
- Alternating C and D single reads each cycle: the `rvalid`s alternate ports with correct data and no drops.
